// File: rtl/vid_mode_pkg.sv
// Shared definitions for the video mode programmer.
// Contents: register index constants in vid write order, register count,
// FSM state encoding, and the stored timing table
// (mode 0 NTSC, mode 1 PAL, modes 2/3 test patterns).
package vid_mode_pkg;

  localparam int NREGS     = 19;
  localparam int TBL_MODES = 4;

  localparam int REG_HP    = 0;
  localparam int REG_HBB   = 1;
  localparam int REG_HBE   = 2;
  localparam int REG_HDB1  = 3;
  localparam int REG_HDB2  = 4;
  localparam int REG_HDE   = 5;
  localparam int REG_HS    = 6;
  localparam int REG_HVS   = 7;
  localparam int REG_HEQ   = 8;
  localparam int REG_VP    = 9;
  localparam int REG_VBB   = 10;
  localparam int REG_VBE   = 11;
  localparam int REG_VDB   = 12;
  localparam int REG_VDE   = 13;
  localparam int REG_VEB   = 14;
  localparam int REG_VEE   = 15;
  localparam int REG_VS    = 16;
  localparam int REG_VI    = 17;
  localparam int REG_VMODE = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAITVB,
    ST_WRITE,
    ST_GAP,
    ST_FIN
  } state_t;

  // Rows are modes, columns follow the REG_* order above. VMODE is the last
  // column so the mode enable is written only after every timing register.
  localparam logic [11:0] MODE_TBL [TBL_MODES][NREGS] = '{
    '{12'd844, 12'd820, 12'd124, 12'd136, 12'd136, 12'd776, 12'd64, 12'd422, 12'd32,
      12'd525, 12'd4, 12'd20, 12'd21, 12'd261, 12'd3, 12'd6, 12'd9, 12'd1, 12'd1},
    '{12'd864, 12'd840, 12'd132, 12'd144, 12'd144, 12'd792, 12'd64, 12'd432, 12'd32,
      12'd625, 12'd4, 12'd24, 12'd23, 12'd310, 12'd2, 12'd5, 12'd7, 12'd1, 12'd3},
    '{12'd100, 12'd90, 12'd20, 12'd24, 12'd24, 12'd84, 12'd8, 12'd50, 12'd4,
      12'd60, 12'd2, 12'd6, 12'd7, 12'd50, 12'd1, 12'd2, 12'd3, 12'd0, 12'd5},
    '{12'd4095, 12'd2730, 12'd1365, 12'd291, 12'd1110, 12'd1929, 12'd2748, 12'd3567, 12'd240,
      12'd3855, 12'd15, 12'd3840, 12'd963, 12'd3132, 12'd273, 12'd546, 12'd819, 12'd1092, 12'd7}
  };

endpackage

// File: rtl/vid_mode_rom.sv
// Combinational timing-table lookup.
// Ports:
//   mode  in  MW  mode index
//   idx   in  IW  register index (REG_* order)
//   val   out 12  table value; 0 for any index outside the table
module vid_mode_rom
  import vid_mode_pkg::*;
#(
  parameter int MW = 2,
  parameter int IW = 5
) (
  input  logic [MW-1:0] mode,
  input  logic [IW-1:0] idx,
  output logic [11:0]   val
);

  always_comb begin
    val = '0;
    for (int m = 0; m < TBL_MODES; m++) begin
      for (int r = 0; r < NREGS; r++) begin
        if (int'(mode) == m && int'(idx) == r) val = MODE_TBL[m][r];
      end
    end
  end

endmodule

// File: rtl/vid_mode_prog.sv
// Mode programmer for the vid timing generator: on req, replays one stored
// timing set into vid's write strobes, one register per WRITE/GAP pair,
// optionally starting at the next vblank rising edge (with a timeout).
// Ports:
//   sys_clk   in   1      clock
//   reset     in   1      synchronous reset, active-high
//   req       in   1      start request, sampled only when idle
//   mode      in   MW     mode index, sampled with req
//   vblank_in in   1      vid vblank
//   wr        out  NREGS  one-hot register write strobes
//   din       out  12     write data, 0 when no strobe
//   busy      out  1      burst in progress
//   done      out  1      one-cycle pulse at burst end
//   err       out  1      one-cycle pulse on rejected mode
//   tmo       out  1      sticky vblank-wait timeout flag
module vid_mode_prog #(
  parameter int NMODES      = 4,
  parameter int NREGS       = 19,
  parameter int WAIT_VBLANK = 1,
  parameter int TIMEOUT     = 1048576,
  localparam int MW         = (NMODES > 1) ? $clog2(NMODES) : 1
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             req,
  input  logic [MW-1:0]    mode,
  input  logic             vblank_in,
  output logic [NREGS-1:0] wr,
  output logic [11:0]      din,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             tmo
);
  import vid_mode_pkg::*;

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [MW-1:0]    mode_q, mode_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             vb_q, vb_d, vbp_q, vbp_d;
  logic             vb_edge;
  logic [NREGS-1:0] wr_q, wr_d;
  logic [11:0]      din_q, din_d, rom_val;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d, tmo_q, tmo_d;

  // Table is addressed with next-state values so the strobe and its data
  // leave registered in the same cycle the FSM enters WRITE.
  vid_mode_rom #(.MW(MW), .IW(IW)) u_rom (
    .mode (mode_d),
    .idx  (idx_d),
    .val  (rom_val)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    tcnt_d  = tcnt_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    vb_d    = vblank_in;
    vbp_d   = vb_q;
    // A level already high on entry never produces an edge here.
    vb_edge = vb_q & ~vbp_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (int'(mode) < NMODES) begin
            mode_d  = mode;
            tmo_d   = 1'b0;
            idx_d   = '0;
            tcnt_d  = '0;
            state_d = (WAIT_VBLANK != 0) ? ST_WAITVB : ST_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WAITVB: begin
        if (vb_edge) begin
          state_d = ST_WRITE;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = ST_WRITE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_WRITE: state_d = ST_GAP;
      ST_GAP: begin
        if (idx_q == IW'(NREGS - 1)) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_WRITE;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    for (int r = 0; r < NREGS; r++) begin
      wr_d[r] = (state_d == ST_WRITE) && (int'(idx_d) == r);
    end
    din_d  = (state_d == ST_WRITE) ? rom_val : '0;
    busy_d = (state_d == ST_WAITVB) || (state_d == ST_WRITE) || (state_d == ST_GAP);
    done_d = (state_d == ST_FIN);
  end

  // State / output register boundary
  always_ff @(posedge sys_clk) begin
    vb_q   <= vb_d;
    vbp_q  <= vbp_d;
    mode_q <= mode_d;
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      tcnt_q  <= '0;
      wr_q    <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign wr   = wr_q;
  assign din  = din_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign tmo  = tmo_q;

endmodule

// File: tb/tb_vid_mode_prog.sv
// Bench for vid_mode_prog: three instances (immediate start, vblank-synced
// with a short timeout, and a 3-mode build for rejected modes) driven by
// directed stimulus and compared every cycle against a burst-schedule model.
module tb_vid_mode_prog;

  localparam int NR  = 19;
  localparam int INF = 32'h3fff_ffff;

  typedef struct {
    bit v;
    int acc;
    int start;
    int mode;
    int tmo_on;
    int kill;
  } burst_t;

  int TBL [4][NR] = '{
    '{844, 820, 124, 136, 136, 776, 64, 422, 32, 525, 4, 20, 21, 261, 3, 6, 9, 1, 1},
    '{864, 840, 132, 144, 144, 792, 64, 432, 32, 625, 4, 24, 23, 310, 2, 5, 7, 1, 3},
    '{100, 90, 20, 24, 24, 84, 8, 50, 4, 60, 2, 6, 7, 50, 1, 2, 3, 0, 5},
    '{4095, 2730, 1365, 291, 1110, 1929, 2748, 3567, 240, 3855, 15, 3840, 963, 3132,
      273, 546, 819, 1092, 7}
  };

  logic clk = 1'b0;
  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;
  bit   chk_en = 1'b0;

  burst_t cur [3];
  burst_t prv [3];
  int     err_at [3];
  int     nwr [3];
  int     ndone [3];

  logic        rst0, rst1, rst2, req0, req1, req2, vb0, vb1, vb2;
  logic [1:0]  mode0, mode1, mode2;
  logic [18:0] wr0, wr1, wr2;
  logic [11:0] din0, din1, din2;
  logic        busy0, busy1, busy2, done0, done1, done2;
  logic        err0, err1, err2, tmo0, tmo1, tmo2;

  vid_mode_prog #(.NMODES(4), .NREGS(19), .WAIT_VBLANK(0), .TIMEOUT(64)) u0 (
    .sys_clk(clk), .reset(rst0), .req(req0), .mode(mode0), .vblank_in(vb0),
    .wr(wr0), .din(din0), .busy(busy0), .done(done0), .err(err0), .tmo(tmo0));
  vid_mode_prog #(.NMODES(4), .NREGS(19), .WAIT_VBLANK(1), .TIMEOUT(64)) u1 (
    .sys_clk(clk), .reset(rst1), .req(req1), .mode(mode1), .vblank_in(vb1),
    .wr(wr1), .din(din1), .busy(busy1), .done(done1), .err(err1), .tmo(tmo1));
  vid_mode_prog #(.NMODES(3), .NREGS(19), .WAIT_VBLANK(0), .TIMEOUT(64)) u2 (
    .sys_clk(clk), .reset(rst2), .req(req2), .mode(mode2), .vblank_in(vb2),
    .wr(wr2), .din(din2), .busy(busy2), .done(done2), .err(err2), .tmo(tmo2));

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string nm, input int d, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d expected=%0d", nm, d, cyc, got, exp);
    end
  endtask

  // Expected outputs at cycle t for one burst: strobe i lands at start+2i,
  // done at start+2*NR, busy from the cycle after acceptance until done.
  function automatic void model(input burst_t b, input int t, output int ew, output int edn,
                                output int eb, output int ed, output int et);
    int endc;
    ew = 0; edn = 0; eb = 0; ed = 0; et = 0;
    if (b.v && t < b.kill) begin
      endc = b.start + 2 * NR;
      eb = (t > b.acc && t < endc) ? 1 : 0;
      ed = (t == endc) ? 1 : 0;
      if (t >= b.start && t < endc && ((t - b.start) % 2 == 0)) begin
        ew  = 1 << ((t - b.start) / 2);
        edn = TBL[b.mode][(t - b.start) / 2];
      end
      et = (t >= b.tmo_on) ? 1 : 0;
    end
  endfunction

  task automatic cmp(input int d, input logic [18:0] w, input logic [11:0] dn, input logic b,
                     input logic dd, input logic e, input logic tm);
    burst_t bb;
    int ew, edn, eb, ed, et;
    bb = (cyc > cur[d].acc) ? cur[d] : prv[d];
    model(bb, cyc, ew, edn, eb, ed, et);
    check("wr", d, int'(w), ew);
    check("din", d, int'(dn), edn);
    check("busy", d, int'(b), eb);
    check("done", d, int'(dd), ed);
    check("err", d, int'(e), (cyc == err_at[d]) ? 1 : 0);
    check("tmo", d, int'(tm), et);
    if (w != 0) nwr[d]++;
    if (dd) ndone[d]++;
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp(0, wr0, din0, busy0, done0, err0, tmo0);
      cmp(1, wr1, din1, busy1, done1, err1, tmo1);
      cmp(2, wr2, din2, busy2, done2, err2, tmo2);
    end
  end

  task automatic go_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic accept(input int d, input int m, input int soff, input bit to);
    prv[d] = cur[d];
    cur[d].v      = 1'b1;
    cur[d].acc    = cyc;
    cur[d].start  = cyc + soff;
    cur[d].mode   = m;
    cur[d].tmo_on = to ? cyc + soff : INF;
    cur[d].kill   = INF;
  endtask

  int c, c2, c3;

  initial begin
    for (int d = 0; d < 3; d++) begin
      cur[d] = '{v: 1'b0, acc: -10, start: INF, mode: 0, tmo_on: INF, kill: INF};
      prv[d] = cur[d];
      err_at[d] = -1;
      nwr[d] = 0;
      ndone[d] = 0;
    end
    {rst0, rst1, rst2} = 3'b111;
    {req0, req1, req2} = 3'b000;
    mode0 = 2'd0; mode1 = 2'd0; mode2 = 2'd0;
    vb0 = 1'b0; vb1 = 1'b1; vb2 = 1'b0;
    go_to(3);
    {rst0, rst1, rst2} = 3'b000;
    chk_en = 1'b1;
    check("rst_wr", 0, int'(wr0), 0);
    check("rst_busy", 1, int'(busy1), 0);
    check("rst_tmo", 1, int'(tmo1), 0);
    go_to(6);

    // Immediate burst, vblank-synced burst with vblank high at req, bad mode
    c = cyc;
    req0 = 1'b1; mode0 = 2'd0; accept(0, 0, 1, 1'b0);
    req1 = 1'b1; mode1 = 2'd1; accept(1, 1, 12, 1'b0);
    req2 = 1'b1; mode2 = 2'd3; err_at[2] = c + 1;
    go_to(c + 1);
    {req0, req1, req2} = 3'b000;
    check("hp_wr", 0, int'(wr0), 1);
    check("hp_din", 0, int'(din0), 844);
    check("busy_on", 0, int'(busy0), 1);
    check("bad_err", 2, int'(err2), 1);
    check("bad_wr", 2, int'(wr2), 0);
    check("bad_busy", 2, int'(busy2), 0);
    check("vbwait_wr", 1, int'(wr1), 0);
    go_to(c + 5);  vb1 = 1'b0;
    go_to(c + 10); vb1 = 1'b1; req0 = 1'b1; mode0 = 2'd1;
    go_to(c + 11); req0 = 1'b0;
    check("vbedge_wr", 1, int'(wr1), 0);
    go_to(c + 12);
    check("vbfirst_wr", 1, int'(wr1), 1);
    check("vbfirst_din", 1, int'(din1), 864);
    go_to(c + 37);
    check("vmode_wr", 0, int'(wr0), 32'h40000);
    check("vmode_din", 0, int'(din0), 1);
    go_to(c + 39);
    check("done", 0, int'(done0), 1);
    check("fin_busy", 0, int'(busy0), 0);
    go_to(c + 55);
    vb1 = 1'b0;
    check("nstrobe", 0, nwr[0], 19);
    check("ndone", 0, ndone[0], 1);
    check("nstrobe", 1, nwr[1], 19);
    check("nstrobe", 2, nwr[2], 0);

    // Timeout on u1, reset mid-burst on u0
    go_to(c + 60);
    c2 = cyc;
    req1 = 1'b1; mode1 = 2'd2; accept(1, 2, 65, 1'b1);
    req0 = 1'b1; mode0 = 2'd3; accept(0, 3, 1, 1'b0);
    go_to(c2 + 1);
    {req0, req1} = 2'b00;
    check("m3_din", 0, int'(din0), 4095);
    go_to(c2 + 15);
    rst0 = 1'b1; cur[0].kill = cyc + 1;
    go_to(c2 + 16);
    rst0 = 1'b0;
    check("rstmid_wr", 0, int'(wr0), 0);
    check("rstmid_busy", 0, int'(busy0), 0);
    go_to(c2 + 20);
    req0 = 1'b1; mode0 = 2'd0; accept(0, 0, 1, 1'b0);
    go_to(c2 + 21);
    req0 = 1'b0;
    check("replay_wr", 0, int'(wr0), 1);
    check("replay_din", 0, int'(din0), 844);
    go_to(c2 + 64);
    check("towait_wr", 1, int'(wr1), 0);
    check("towait_tmo", 1, int'(tmo1), 0);
    go_to(c2 + 65);
    check("to_wr", 1, int'(wr1), 1);
    check("to_din", 1, int'(din1), 100);
    check("to_tmo", 1, int'(tmo1), 1);
    go_to(c2 + 105);
    check("nstrobe2", 0, nwr[0], 46);

    // Next accepted req clears tmo; good mode on the 3-mode build
    go_to(c2 + 110);
    c3 = cyc;
    check("tmo_hold", 1, int'(tmo1), 1);
    req1 = 1'b1; mode1 = 2'd0; accept(1, 0, 5, 1'b0);
    req2 = 1'b1; mode2 = 2'd2; accept(2, 2, 1, 1'b0);
    go_to(c3 + 1);
    {req1, req2} = 2'b00;
    check("tmo_clr", 1, int'(tmo1), 0);
    check("m2_din", 2, int'(din2), 100);
    go_to(c3 + 3); vb1 = 1'b1;
    go_to(c3 + 5);
    check("vb2_wr", 1, int'(wr1), 1);
    check("vb2_din", 1, int'(din1), 844);
    go_to(c3 + 50);
    check("ndone_all", 2, ndone[2], 1);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
